// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: ALU control codes, forwarding selects, branch funct3 values.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_ctrl_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/alu.sv
// Combinational RV32I integer ALU; unknown control codes produce zero.
module alu #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    import riscv_pkg::*;

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    assign shamt = b[SHW-1:0];

    always_comb begin
        result = '0;
        case (alu_ctrl)
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_ADD:  result = a + b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SUB:  result = a - b;
            ALU_SRA:  result = $signed(a) >>> shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, a < b};
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution and the EX/MEM register.
module ex_stage #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    input  logic [3:0]      alu_ctrl_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            alu_src_i,
    input  logic [1:0]      fwd_a_i,
    input  logic [1:0]      fwd_b_i,
    input  logic [XLEN-1:0] wb_fwd_data_i,
    input  logic [4:0]      rd_i,
    input  logic            reg_write_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic            mem_to_reg_i,
    input  logic            branch_i,
    output logic            mem_valid_o,
    output logic [XLEN-1:0] mem_alu_result_o,
    output logic [XLEN-1:0] mem_store_data_o,
    output logic [XLEN-1:0] mem_branch_target_o,
    output logic [4:0]      mem_rd_o,
    output logic            mem_reg_write_o,
    output logic            mem_mem_read_o,
    output logic            mem_mem_write_o,
    output logic            mem_mem_to_reg_o,
    output logic            mem_branch_taken_o
);
    import riscv_pkg::*;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] store_data;
        logic [XLEN-1:0] branch_target;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            branch_taken;
    } exmem_t;

    exmem_t q, d;

    logic [XLEN-1:0] op_a, fwd_b, op_b, alu_result;
    logic            br_cond;
    logic            unused_alu_zero;

    // FWD_MEM reads the register output, i.e. the value from before this edge.
    always_comb begin
        case (fwd_a_i)
            FWD_WB:  op_a = wb_fwd_data_i;
            FWD_MEM: op_a = q.alu_result;
            default: op_a = rs1_data_i;
        endcase
        case (fwd_b_i)
            FWD_WB:  fwd_b = wb_fwd_data_i;
            FWD_MEM: fwd_b = q.alu_result;
            default: fwd_b = rs2_data_i;
        endcase
    end

    assign op_b = alu_src_i ? imm_i : fwd_b;

    alu #(.XLEN(XLEN)) u_alu (
        .a        (op_a),
        .b        (op_b),
        .alu_ctrl (alu_ctrl_i),
        .result   (alu_result),
        .zero     (unused_alu_zero)
    );

    always_comb begin
        br_cond = 1'b0;
        case (funct3_i)
            F3_BEQ:  br_cond = (op_a == fwd_b);
            F3_BNE:  br_cond = (op_a != fwd_b);
            F3_BLT:  br_cond = ($signed(op_a) <  $signed(fwd_b));
            F3_BGE:  br_cond = ($signed(op_a) >= $signed(fwd_b));
            F3_BLTU: br_cond = (op_a <  fwd_b);
            F3_BGEU: br_cond = (op_a >= fwd_b);
            default: br_cond = 1'b0;
        endcase
    end

    always_comb begin
        d = '0;
        if (in_valid_i) begin
            d.valid         = 1'b1;
            d.alu_result    = alu_result;
            d.store_data    = fwd_b;
            d.branch_target = pc_i + imm_i;
            d.rd            = rd_i;
            d.reg_write     = reg_write_i;
            d.mem_read      = mem_read_i;
            d.mem_write     = mem_write_i;
            d.mem_to_reg    = mem_to_reg_i;
            d.branch_taken  = branch_i & br_cond;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            q <= '0;
        else if (flush_i)
            q <= '0;
        else if (!stall_i)
            q <= d;
    end

    assign mem_valid_o         = q.valid;
    assign mem_alu_result_o    = q.alu_result;
    assign mem_store_data_o    = q.store_data;
    assign mem_branch_target_o = q.branch_target;
    assign mem_rd_o            = q.rd;
    assign mem_reg_write_o     = q.reg_write;
    assign mem_mem_read_o      = q.mem_read;
    assign mem_mem_write_o     = q.mem_write;
    assign mem_mem_to_reg_o    = q.mem_to_reg;
    assign mem_branch_taken_o  = q.branch_taken;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus randomized traffic against a reference model.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall_i, flush_i, in_valid_i;
    logic [3:0]  alu_ctrl_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_data_i, rs2_data_i, imm_i, pc_i, wb_fwd_data_i;
    logic        alu_src_i;
    logic [1:0]  fwd_a_i, fwd_b_i;
    logic [4:0]  rd_i;
    logic        reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i, branch_i;
    logic        mem_valid_o;
    logic [31:0] mem_alu_result_o, mem_store_data_o, mem_branch_target_o;
    logic [4:0]  mem_rd_o;
    logic        mem_reg_write_o, mem_mem_read_o, mem_mem_write_o, mem_mem_to_reg_o, mem_branch_taken_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the EX/MEM register contents
    logic        m_v, m_rw, m_mr, m_mw, m_m2r, m_bt;
    logic [31:0] m_res, m_st, m_tgt;
    logic [4:0]  m_rd;

    ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .alu_ctrl_i(alu_ctrl_i), .funct3_i(funct3_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i), .pc_i(pc_i),
        .alu_src_i(alu_src_i), .fwd_a_i(fwd_a_i), .fwd_b_i(fwd_b_i),
        .wb_fwd_data_i(wb_fwd_data_i), .rd_i(rd_i), .reg_write_i(reg_write_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .mem_to_reg_i(mem_to_reg_i),
        .branch_i(branch_i), .mem_valid_o(mem_valid_o), .mem_alu_result_o(mem_alu_result_o),
        .mem_store_data_o(mem_store_data_o), .mem_branch_target_o(mem_branch_target_o),
        .mem_rd_o(mem_rd_o), .mem_reg_write_o(mem_reg_write_o), .mem_mem_read_o(mem_mem_read_o),
        .mem_mem_write_o(mem_mem_write_o), .mem_mem_to_reg_o(mem_mem_to_reg_o),
        .mem_branch_taken_o(mem_branch_taken_o)
    );

    always #5 clk = ~clk;

    wire [106:0] obs = {mem_valid_o, mem_alu_result_o, mem_store_data_o, mem_branch_target_o,
                        mem_rd_o, mem_reg_write_o, mem_mem_read_o, mem_mem_write_o,
                        mem_mem_to_reg_o, mem_branch_taken_o};
    wire [106:0] mdl = {m_v, m_res, m_st, m_tgt, m_rd, m_rw, m_mr, m_mw, m_m2r, m_bt};

    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (c)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return a + b;
            4'd3: return a ^ b;
            4'd4: return a << sh;
            4'd5: return a >> sh;
            4'd6: return a - b;
            4'd7: return a[31] ? ~((~a) >> sh) : (a >> sh);
            4'd8: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_br(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return int'(a) < int'(b);
            3'd5: return int'(a) >= int'(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_clear();
        {m_v, m_res, m_st, m_tgt, m_rd, m_rw, m_mr, m_mw, m_m2r, m_bt} = '0;
    endtask

    // Advance the model from the current inputs, then step one clock and settle.
    task automatic tick();
        logic [31:0] a, b;
        if (!rst_n || flush_i || (!stall_i && !in_valid_i)) begin
            model_clear();
        end else if (!stall_i) begin
            a = (fwd_a_i == 2'd1) ? wb_fwd_data_i : (fwd_a_i == 2'd2) ? m_res : rs1_data_i;
            b = (fwd_b_i == 2'd1) ? wb_fwd_data_i : (fwd_b_i == 2'd2) ? m_res : rs2_data_i;
            m_res = ref_alu(alu_ctrl_i, a, alu_src_i ? imm_i : b);
            m_st  = b;
            m_tgt = pc_i + imm_i;
            m_bt  = branch_i & ref_br(funct3_i, a, b);
            m_v = 1'b1; m_rd = rd_i; m_rw = reg_write_i; m_mr = mem_read_i;
            m_mw = mem_write_i; m_m2r = mem_to_reg_i;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rst_n = 1'b1; stall_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0;
        alu_ctrl_i = 4'd2; funct3_i = 3'd0; rs1_data_i = '0; rs2_data_i = '0;
        imm_i = '0; pc_i = '0; wb_fwd_data_i = '0; alu_src_i = 1'b0;
        fwd_a_i = 2'd0; fwd_b_i = 2'd0; rd_i = '0; reg_write_i = 1'b0;
        mem_read_i = 1'b0; mem_write_i = 1'b0; mem_to_reg_i = 1'b0; branch_i = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0; in_valid_i = 1'b1; reg_write_i = 1'b1; mem_read_i = 1'b1;
        mem_write_i = 1'b1; branch_i = 1'b1; rs1_data_i = 32'h55; rs2_data_i = 32'h55;
        pc_i = 32'h40; imm_i = 32'h4; rd_i = 5'd7;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (obs !== '0) begin
                n_fail++; $display("FAIL reset_hold[%0d]: got %h required 0", i, obs);
            end
        end
        rst_n = 1'b1; in_valid_i = 1'b0;
        tick();
        n_checks++;
        if (obs !== '0) begin
            n_fail++; $display("FAIL reset_release: got %h required 0", obs);
        end
    endtask

    task automatic test_alu_sweep();
        logic [3:0]  codes [11] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd15};
        logic [31:0] exps  [11] = '{32'hFFFFFFF4, 32'hFFFFFFEC, 32'h0, 32'hFFFFFFF4, 32'hFFFFFFF4,
                                    32'hFFFFFF00, 32'h0FFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0};
        set_idle();
        in_valid_i = 1'b1; rs1_data_i = 32'hFFFFFFF0; rs2_data_i = 32'h4;
        for (int i = 0; i < 11; i++) begin
            alu_ctrl_i = codes[i];
            tick();
            n_checks++;
            if (mem_alu_result_o !== exps[i] || mem_valid_o !== 1'b1) begin
                n_fail++;
                $display("FAIL alu_code_%0d: got %h valid %b required %h valid 1",
                         codes[i], mem_alu_result_o, mem_valid_o, exps[i]);
            end
        end
    endtask

    task automatic test_fwd_chain();
        set_idle();
        in_valid_i = 1'b1; alu_ctrl_i = 4'd2; alu_src_i = 1'b1; rs1_data_i = 32'd5; imm_i = 32'd3;
        tick();
        n_checks++;
        if (mem_alu_result_o !== 32'd8) begin
            n_fail++; $display("FAIL fwd_addi: got %0d required 8", mem_alu_result_o);
        end
        fwd_a_i = 2'b10; rs1_data_i = 32'd77; imm_i = 32'd1;
        tick();
        n_checks++;
        if (mem_alu_result_o !== 32'd9) begin
            n_fail++; $display("FAIL fwd_mem: got %0d required 9", mem_alu_result_o);
        end
        fwd_a_i = 2'b01; wb_fwd_data_i = 32'd100; alu_src_i = 1'b0; rs2_data_i = 32'd1;
        tick();
        n_checks++;
        if (mem_alu_result_o !== 32'd101) begin
            n_fail++; $display("FAIL fwd_wb: got %0d required 101", mem_alu_result_o);
        end
    endtask

    task automatic test_branches();
        set_idle();
        in_valid_i = 1'b1; branch_i = 1'b1; funct3_i = 3'b100;
        rs1_data_i = 32'hFFFFFFFF; rs2_data_i = 32'h1; pc_i = 32'h100; imm_i = 32'hFFFFFFF0;
        tick();
        n_checks++;
        if (mem_branch_taken_o !== 1'b1 || mem_branch_target_o !== 32'hF0) begin
            n_fail++;
            $display("FAIL blt: got taken %b target %h required taken 1 target 000000f0",
                     mem_branch_taken_o, mem_branch_target_o);
        end
        funct3_i = 3'b110;
        tick();
        n_checks++;
        if (mem_branch_taken_o !== 1'b0) begin
            n_fail++; $display("FAIL bltu: got taken %b required 0", mem_branch_taken_o);
        end
        funct3_i = 3'b000; branch_i = 1'b0; rs2_data_i = 32'hFFFFFFFF;
        tick();
        n_checks++;
        if (mem_branch_taken_o !== 1'b0) begin
            n_fail++; $display("FAIL beq_nobranch: got taken %b required 0", mem_branch_taken_o);
        end
    endtask

    task automatic test_stall_flush();
        set_idle();
        in_valid_i = 1'b1; rs1_data_i = 32'd7; rs2_data_i = 32'd9; rd_i = 5'd3; reg_write_i = 1'b1;
        tick();
        n_checks++;
        if (mem_alu_result_o !== 32'd16) begin
            n_fail++; $display("FAIL stall_preload: got %0d required 16", mem_alu_result_o);
        end
        stall_i = 1'b1; mem_write_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rs1_data_i = $urandom; rs2_data_i = $urandom; rd_i = 5'($urandom); alu_ctrl_i = 4'($urandom);
            tick();
            n_checks++;
            if ({mem_valid_o, mem_alu_result_o, mem_store_data_o, mem_rd_o, mem_reg_write_o, mem_mem_write_o}
                !== {1'b1, 32'd16, 32'd9, 5'd3, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got v%b res %h st %h rd %0d rw %b mw %b required v1 res 10 st 9 rd 3 rw 1 mw 0",
                         i, mem_valid_o, mem_alu_result_o, mem_store_data_o, mem_rd_o, mem_reg_write_o, mem_mem_write_o);
            end
        end
        flush_i = 1'b1;
        tick();
        n_checks++;
        if (mem_valid_o !== 1'b0 || mem_mem_write_o !== 1'b0 || mem_alu_result_o !== 32'd0) begin
            n_fail++;
            $display("FAIL stall_flush: got v%b mw %b res %h required v0 mw 0 res 0",
                     mem_valid_o, mem_mem_write_o, mem_alu_result_o);
        end
        flush_i = 1'b0; stall_i = 1'b0; mem_write_i = 1'b0;
        alu_ctrl_i = 4'd2; rs1_data_i = 32'd1; rs2_data_i = 32'd2; rd_i = 5'd4;
        tick();
        n_checks++;
        if (mem_valid_o !== 1'b1 || mem_alu_result_o !== 32'd3 || mem_rd_o !== 5'd4) begin
            n_fail++;
            $display("FAIL post_flush_load: got v%b res %h rd %0d required v1 res 3 rd 4",
                     mem_valid_o, mem_alu_result_o, mem_rd_o);
        end
    endtask

    task automatic test_store();
        set_idle();
        in_valid_i = 1'b1; mem_write_i = 1'b1; alu_src_i = 1'b1; imm_i = 32'd8;
        rs1_data_i = 32'h1000; rs2_data_i = 32'h12345678; fwd_b_i = 2'b01; wb_fwd_data_i = 32'hDEADBEEF;
        tick();
        n_checks++;
        if (mem_alu_result_o !== 32'h1008 || mem_store_data_o !== 32'hDEADBEEF || mem_mem_write_o !== 1'b1) begin
            n_fail++;
            $display("FAIL store: got addr %h data %h mw %b required addr 00001008 data deadbeef mw 1",
                     mem_alu_result_o, mem_store_data_o, mem_mem_write_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            flush_i = ($urandom_range(0, 9) == 0);
            stall_i = ($urandom_range(0, 5) == 0);
            in_valid_i = ($urandom_range(0, 7) != 0);
            alu_ctrl_i = 4'($urandom); funct3_i = 3'($urandom);
            rs1_data_i = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            rs2_data_i = ($urandom_range(0, 3) == 0) ? rs1_data_i : $urandom;
            imm_i = $urandom; pc_i = $urandom; wb_fwd_data_i = $urandom;
            alu_src_i = 1'($urandom); fwd_a_i = 2'($urandom); fwd_b_i = 2'($urandom);
            rd_i = 5'($urandom); reg_write_i = 1'($urandom); mem_read_i = 1'($urandom);
            mem_write_i = 1'($urandom); mem_to_reg_i = 1'($urandom); branch_i = 1'($urandom);
            tick();
            n_checks++;
            if (obs !== mdl) begin
                n_fail++; $display("FAIL random[%0d]: got %h required %h", i, obs, mdl);
            end
        end
    endtask

    initial begin
        set_idle();
        rst_n = 1'b0;
        model_clear();
        test_reset();
        test_alu_sweep();
        test_fwd_chain();
        test_branches();
        test_stall_flush();
        test_store();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the pipelined RV32I core, directly downstream of ALU control. It takes the 4-bit `alu_ctrl` code and the ID/EX operands, applies forwarding, and computes the ALU result and branch outcome. Results are captured in the EX/MEM pipeline register, which supports stall and flush. Outputs feed the MEM stage, the forwarding network and the PC-redirect logic.

## Interface
- `XLEN`, 32: datapath width.
- `clk` in 1: clock, all state updates on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `stall_i` in 1: hold the EX/MEM register.
- `flush_i` in 1: load a bubble into EX/MEM.
- `in_valid_i` in 1: ID/EX holds a real instruction.
- `alu_ctrl_i` in 4: ALU operation code.
- `funct3_i` in 3: branch condition select.
- `rs1_data_i`, `rs2_data_i`, `imm_i`, `pc_i` in XLEN: operands, immediate and instruction PC.
- `alu_src_i` in 1: ALU operand B source. 0 = forwarded rs2, 1 = imm.
- `fwd_a_i`, `fwd_b_i` in 2: forwarding selects.
- `wb_fwd_data_i` in XLEN: write-back value for forwarding.
- `rd_i` in 5, plus `reg_write_i`, `mem_read_i`, `mem_write_i`, `mem_to_reg_i`, `branch_i` in 1 each: control passthrough.
- `mem_valid_o` out 1; `mem_alu_result_o`, `mem_store_data_o`, `mem_branch_target_o` out XLEN; `mem_rd_o` out 5.
- `mem_reg_write_o`, `mem_mem_read_o`, `mem_mem_write_o`, `mem_mem_to_reg_o`, `mem_branch_taken_o` out 1 each.

## Operation
- **Forwarding selects.** The same rule applies to operand A (from rs1) and to the forwarded rs2 value.
  - 00: register value.
  - 01: `wb_fwd_data_i`.
  - 10: `mem_alu_result_o`.
  - 11: register value (reserved).
- **Operands.**
  - Operand A is the forwarded rs1.
  - Store data is the forwarded rs2, taken before the `alu_src_i` mux.
- **ALU codes.**
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL.
  - 0110 SUB, 0111 SRA, 1000 SLT (signed), 1001 SLTU.
  - Any other code gives a result of 0.
- **Arithmetic rules.**
  - ADD and SUB wrap modulo 2^32.
  - The shift amount is B[4:0].
  - SRA replicates A[31].
  - SLT and SLTU produce 0 or 1, zero-extended.
- **Branch condition.** Compares forwarded rs1 against forwarded rs2, independent of `alu_src_i` and `alu_ctrl_i`.
  - funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
  - 010 and 011 are never taken.
  - Taken = `branch_i & in_valid_i & condition`.
- **Branch target.** `pc_i + imm_i`, wrapping.
- **EX/MEM register update.** Priority order:
  1. Reset: all outputs clear.
  2. Flush: bubble.
  3. Stall: hold.
  4. Otherwise: load.
- **Bubble.** A bubble occurs on flush, or on a load with `in_valid_i`=0.
  - `mem_valid_o`, `mem_reg_write_o`, `mem_mem_read_o`, `mem_mem_write_o`, `mem_mem_to_reg_o` and `mem_branch_taken_o` become 0.
  - Data fields and `mem_rd_o` load 0.
- **Stall hold.** Every field holds, including valid. Forwarding select 10 keeps returning the held result.

## Timing
- **Reset value.** Every output is 0 after the first rising edge with `rst_n`=0.
- **Reset mid-operation.** Reset discards any held instruction. There is no partial state.
- **Latency.** One cycle: inputs at edge N appear on `mem_*` after edge N.
- **Combinational path.** Inputs pass through the forwarding muxes and ALU to the register. No combinational path goes from inputs to outputs.
- **Same-cycle forwarding.** Select 10 uses the register value present before the edge. A back-to-back dependent ALU pair therefore completes with no bubble.
- **Stall and flush together.** Flush wins.
- **Branch redirect.** `mem_branch_taken_o` and `mem_branch_target_o` are valid one cycle after EX. The hazard unit flushes IF/ID and ID/EX that cycle. This block does not flush itself.

## Structure
- **Package `riscv_pkg`.**
  - `alu_ctrl_t` enum holding the ten codes above, shared with ALU control.
  - Forwarding-select localparams `FWD_REG`, `FWD_WB`, `FWD_MEM`.
  - Branch funct3 localparams.
  - `XLEN` default.
- **Sub-module `alu`.** Purely combinational.
  - Inputs: `a`, `b`, `alu_ctrl`.
  - Outputs: `result`, `zero`.
  - `zero` is unused here but is kept for reuse.
- **`ex_stage` itself.** Forwarding muxes, branch comparator, target adder and the EX/MEM register.

## Test plan
- **Reset.** Drive valid inputs with `rst_n`=0 for 2 cycles, then release with `in_valid_i`=0. All outputs stay 0.
- **ALU sweep, registers only.** A=0xFFFFFFF0, B=0x00000004, `alu_src_i`=0, `fwd_*`=00, one cycle per code. Next-cycle `mem_alu_result_o`:
  - ADD 0xFFFFFFF4, SUB 0xFFFFFFEC, AND 0, OR 0xFFFFFFF4, XOR 0xFFFFFFF4.
  - SLL 0xFFFFFF00, SRL 0x0FFFFFFF, SRA 0xFFFFFFFF.
  - SLT 1, SLTU 0.
  - Code 1111 gives 0.
- **Forwarding chain.**
  - `addi` rs1=5, imm=3 gives 8.
  - Next instruction with `fwd_a_i`=10, imm=1 gives 9.
  - Then `fwd_a_i`=01 with `wb_fwd_data_i`=100 and ADD of rs2=1 gives 101.
- **Branches.**
  - BLT with rs1=0xFFFFFFFF, rs2=1, `pc_i`=0x100, `imm_i`=0xFFFFFFF0: taken, target 0xF0.
  - BLTU on the same operands: not taken.
  - BEQ with `branch_i`=0: not taken.
- **Stall and flush.**
  - Stall for 3 cycles while inputs change: all outputs hold their pre-stall values.
  - Assert `flush_i` and `stall_i` together: bubble with `mem_valid_o`=0 and `mem_mem_write_o`=0.
  - Release both: the next instruction loads normally.
- **Store data path.** `mem_write_i`=1, `alu_src_i`=1, imm=8, rs1=0x1000, `fwd_b_i`=01 with `wb_fwd_data_i`=0xDEADBEEF. Required: `mem_alu_result_o`=0x1008 and `mem_store_data_o`=0xDEADBEEF.
